funct_generator_fifo: RTL and testbench

- Downstream buffer for the function-generator adder.
- Captures each adder result (data_o of funct_generator_adder) on a write strobe and holds it in a circular buffer.
- The LUT/output stage drains it with a read strobe and a registered, 1-cycle-latency read port.
- Decouples generator update rate from consumer rate; reports full/empty/almost-full and sticky error flags.

---
 rtl/funct_generator_fifo.sv | 113 +++++++++++
 tb/tb_funct_generator_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/funct_generator_fifo.sv
// Circular sample buffer between the function-generator adder and the LUT/output stage.
// The write side captures adder results; the read side has a registered port with 1-cycle latency.
`ifndef LUT_ADDR
`define LUT_ADDR 10
`endif

module funct_generator_fifo #(
  parameter int DATA_WIDTH = `LUT_ADDR,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clrh,
  input  logic                         wr_en_i,
  input  logic [DATA_WIDTH-1:0]        data_i,
  input  logic                         rd_en_i,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         data_valid_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         almost_full_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;

  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  // A read frees a slot in the same edge, so a full buffer still takes a paired write.
  assign w_rd_acc = rd_en_i && !w_empty;
  assign w_wr_acc = wr_en_i && (!w_full || w_rd_acc);

  // Storage is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !clrh && !rst) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clrh) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      // Read-first: on a full rd+wr both pointers alias and the old entry is returned.
      if (w_rd_acc) begin
        r_data   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_valid <= w_rd_acc;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (wr_en_i && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end
      if (rd_en_i && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign data_o        = r_data;
  assign data_valid_o  = r_valid;
  assign full_o        = w_full;
  assign empty_o       = w_empty;
  assign almost_full_o = (r_count >= AF_C);
  assign count_o       = r_count;
  assign overflow_o    = r_overflow;
  assign underflow_o   = r_underflow;

  a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= DEPTH_C);
  a_full_empty:  assert property (@(posedge clk) disable iff (rst) !(w_full && w_empty));

endmodule

// File: tb/tb_funct_generator_fifo.sv
// Directed bench for funct_generator_fifo (DEPTH=4, AF_LEVEL=2, 8-bit data):
// a table of per-cycle vectors plus a hand-written asynchronous reset sequence.
`timescale 1ns/1ps

module tb_funct_generator_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       clrh;
  logic       wr_en_i;
  logic [7:0] data_i;
  logic       rd_en_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       full_o;
  logic       empty_o;
  logic       almost_full_o;
  logic [2:0] count_o;
  logic       overflow_o;
  logic       underflow_o;

  int n_checks = 0;
  int n_errors = 0;

  funct_generator_fifo #(
    .DATA_WIDTH(8),
    .DEPTH     (4),
    .AF_LEVEL  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clrh         (clrh),
    .wr_en_i      (wr_en_i),
    .data_i       (data_i),
    .rd_en_i      (rd_en_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .almost_full_o(almost_full_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .underflow_o  (underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wr; int din; int rd; int cl;
    int dout; int dv; int cnt; int full; int empty; int af; int ovf; int unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int wr, input int din, input int rd, input int cl,
                     input int dout, input int dv, input int cnt, input int full,
                     input int empty, input int af, input int ovf, input int unf);
    vec_t v;
    v = '{wr, din, rd, cl, dout, dv, cnt, full, empty, af, ovf, unf};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input int dout, input int dv,
                           input int cnt, input int full, input int empty, input int af,
                           input int ovf, input int unf);
    check({tag, " data_o"},        idx, int'(data_o),        dout);
    check({tag, " data_valid_o"},  idx, int'(data_valid_o),  dv);
    check({tag, " count_o"},       idx, int'(count_o),       cnt);
    check({tag, " full_o"},        idx, int'(full_o),        full);
    check({tag, " empty_o"},       idx, int'(empty_o),       empty);
    check({tag, " almost_full_o"}, idx, int'(almost_full_o), af);
    check({tag, " overflow_o"},    idx, int'(overflow_o),    ovf);
    check({tag, " underflow_o"},   idx, int'(underflow_o),   unf);
  endtask

  task automatic drive(input int wr, input int din, input int rd, input int cl);
    wr_en_i = wr[0];
    data_i  = din[7:0];
    rd_en_i = rd[0];
    clrh    = cl[0];
  endtask

  initial begin
    //  wr din rd cl | dout dv cnt full empty af ovf unf
    // three writes then three reads
    add(1, 3, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 5, 0, 0,   0, 0, 2, 0, 0, 1, 0, 0);
    add(1, 7, 0, 0,   0, 0, 3, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0,   3, 1, 2, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0,   5, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0,   7, 1, 0, 0, 1, 0, 0, 0);
    // fill to full, fifth write dropped, drain
    add(1, 1, 0, 0,   7, 0, 1, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0,   7, 0, 2, 0, 0, 1, 0, 0);
    add(1, 3, 0, 0,   7, 0, 3, 0, 0, 1, 0, 0);
    add(1, 4, 0, 0,   7, 0, 4, 1, 0, 1, 0, 0);
    add(1, 9, 0, 0,   7, 0, 4, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0,   1, 1, 3, 0, 0, 1, 1, 0);
    add(0, 0, 1, 0,   2, 1, 2, 0, 0, 1, 1, 0);
    add(0, 0, 1, 0,   3, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0,   4, 1, 0, 0, 1, 0, 1, 0);
    // read while empty, then rd+wr on empty accepts only the write
    add(0, 0, 1, 0,   4, 0, 0, 0, 1, 0, 1, 1);
    add(1, 6, 1, 0,   4, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0,   6, 1, 0, 0, 1, 0, 1, 1);
    // flush clears flags and data_o
    add(0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0, 0);
    // full rd+wr keeps count at DEPTH, drain crosses the pointer wrap
    add(1, 1, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0,   0, 0, 2, 0, 0, 1, 0, 0);
    add(1, 3, 0, 0,   0, 0, 3, 0, 0, 1, 0, 0);
    add(1, 4, 0, 0,   0, 0, 4, 1, 0, 1, 0, 0);
    add(1, 8, 1, 0,   1, 1, 4, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0,   2, 1, 3, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0,   3, 1, 2, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0,   4, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0,   8, 1, 0, 0, 1, 0, 0, 0);
    // three entries with overflow set, then clrh with a write
    add(1, 10, 0, 0,  8, 0, 1, 0, 0, 0, 0, 0);
    add(1, 11, 0, 0,  8, 0, 2, 0, 0, 1, 0, 0);
    add(1, 12, 0, 0,  8, 0, 3, 0, 0, 1, 0, 0);
    add(1, 13, 0, 0,  8, 0, 4, 1, 0, 1, 0, 0);
    add(1, 14, 0, 0,  8, 0, 4, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0,  10, 1, 3, 0, 0, 1, 1, 0);
    add(1, 15, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 0, 1);

    rst = 1'b1;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].cl);
      @(posedge clk);
      #1;
      $display("step %0d wr=%0d din=%0d rd=%0d clrh=%0d -> data_o=%0d valid=%0d count=%0d f/e/af=%0d%0d%0d ovf=%0d unf=%0d",
               i, vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].cl, data_o, data_valid_o,
               count_o, full_o, empty_o, almost_full_o, overflow_o, underflow_o);
      check_all("vec", i, vecs[i].dout, vecs[i].dv, vecs[i].cnt, vecs[i].full,
                vecs[i].empty, vecs[i].af, vecs[i].ovf, vecs[i].unf);
    end

    // Asynchronous reset in the middle of a read burst (underflow is still set from above).
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 20 + k, 0, 0);
    end
    @(negedge clk);
    drive(0, 0, 1, 0);
    @(posedge clk);
    #1;
    check("burst first read", 100, int'(data_o), 20);
    #2;
    rst = 1'b1;
    #1;
    $display("async rst mid-burst -> data_o=%0d valid=%0d count=%0d ovf=%0d unf=%0d",
             data_o, data_valid_o, count_o, overflow_o, underflow_o);
    check_all("async_rst", 101, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    drive(1, 2, 0, 0);
    @(posedge clk);
    #1;
    $display("post-reset write 2 -> count=%0d", count_o);
    check("post-reset count", 102, int'(count_o), 1);
    @(negedge clk);
    drive(0, 0, 1, 0);
    @(posedge clk);
    #1;
    $display("post-reset read -> data_o=%0d valid=%0d", data_o, data_valid_o);
    check_all("post_rst_read", 103, 2, 1, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("data_o hold", 104, int'(data_o), 2);
    check("valid drop", 104, int'(data_valid_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
